// File: rtl/stream_buffer_flushable_pkg.sv
// Shared constants and parameter-legality helper for the flushable stream buffer.
// No state, no latency, no flow control of its own.
package stream_buffer_flushable_pkg;

    localparam int unsigned SBF_MIN_DEPTH = 2;

    function automatic bit sbf_thresh_legal(input int depth, input int thresh);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/stream_buffer_ptr.sv
// Modulo-Depth pointer with increment and synchronous clear (clear wins).
// Pointer value is registered: a change shows one cycle later; no handshake.
module stream_buffer_ptr
    import stream_buffer_flushable_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     inc_i,
    output logic [$clog2(Depth)-1:0] ptr_o
);

    localparam int PW = $clog2(Depth);

    if (Depth < SBF_MIN_DEPTH) begin : g_depth_chk
        $error("stream_buffer_ptr: Depth must be >= 2");
    end

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Explicit wrap so non-power-of-two depths never index past Depth-1.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PW'(Depth - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/stream_buffer_flushable.sv
// Depth-entry circular stream buffer with same-cycle flush; 1-cycle latency.
// ready_o/valid_o come from registered fill level (masked by flush_i) so no ready/valid combinational path.
module stream_buffer_flushable
    import stream_buffer_flushable_pkg::*;
#(
    parameter type T                = logic,
    parameter int  Depth            = 2,
    parameter int  AlmostFullThresh = Depth - 1,
    parameter bit  Bypass           = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  T                           data_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output T                           data_o,
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       almost_full_o
);

    localparam int UW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);

    if (Depth < SBF_MIN_DEPTH) begin : g_depth_chk
        $error("stream_buffer_flushable: Depth must be >= 2");
    end
    if (!sbf_thresh_legal(Depth, AlmostFullThresh)) begin : g_thresh_chk
        $error("stream_buffer_flushable: AlmostFullThresh must be in 1..Depth");
    end

    if (Bypass) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_i, flush_i};
        assign valid_o       = valid_i;
        assign ready_o       = ready_i;
        assign data_o        = data_i;
        assign usage_o       = '0;
        assign almost_full_o = 1'b0;
    end else begin : g_buf
        T              mem_q [Depth];
        logic [UW-1:0] usage_q;
        logic [UW-1:0] usage_d;
        logic          af_q;
        logic          af_d;
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic          push;
        logic          pop;

        assign ready_o = (usage_q != UW'(Depth)) && !flush_i;
        assign valid_o = (usage_q != '0) && !flush_i;
        assign push    = valid_i && ready_o;
        assign pop     = valid_o && ready_i;
        assign data_o  = mem_q[rd_ptr];

        stream_buffer_ptr #(.Depth(Depth)) u_rd_ptr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (flush_i),
            .inc_i (pop),
            .ptr_o (rd_ptr)
        );

        stream_buffer_ptr #(.Depth(Depth)) u_wr_ptr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (flush_i),
            .inc_i (push),
            .ptr_o (wr_ptr)
        );

        always_comb begin
            usage_d = usage_q;
            if (flush_i) begin
                usage_d = '0;
            end else if (push && !pop) begin
                usage_d = usage_q + 1'b1;
            end else if (pop && !push) begin
                usage_d = usage_q - 1'b1;
            end
        end

        assign af_d = (usage_d >= UW'(AlmostFullThresh));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                usage_q <= '0;
                af_q    <= 1'b0;
                for (int i = 0; i < Depth; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                usage_q <= usage_d;
                af_q    <= af_d;
                if (push) begin
                    mem_q[wr_ptr] <= data_i;
                end
            end
        end

        assign usage_o       = usage_q;
        assign almost_full_o = af_q;
    end

    // A word offered during flush is silently dropped; flag it in simulation.
    a_no_valid_on_flush : assert property (@(posedge clk_i) disable iff (rst_i) !(valid_i && flush_i))
        else $warning("stream_buffer_flushable: valid_i high during flush_i, word dropped");

endmodule

// File: tb/tb_stream_buffer_flushable.sv
// Directed vector table plus multi-cycle sequences for the flushable stream buffer.
// Depth=4, AlmostFullThresh=3 instance plus a Bypass=1 instance.
module tb_stream_buffer_flushable;

    typedef logic [7:0] byte_t;

    logic       clk_i;
    logic       rst_i;
    logic       flush_i;
    logic       valid_i;
    logic       ready_o;
    byte_t      data_i;
    logic       valid_o;
    logic       ready_i;
    byte_t      data_o;
    logic [2:0] usage_o;
    logic       almost_full_o;

    logic       b_flush;
    logic       b_valid_i;
    logic       b_ready_o;
    byte_t      b_data_i;
    logic       b_valid_o;
    logic       b_ready_i;
    byte_t      b_data_o;
    logic [2:0] b_usage_o;
    logic       b_almost_full_o;

    stream_buffer_flushable #(
        .T(byte_t), .Depth(4), .AlmostFullThresh(3), .Bypass(1'b0)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_i        (data_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .usage_o       (usage_o),
        .almost_full_o (almost_full_o)
    );

    stream_buffer_flushable #(
        .T(byte_t), .Depth(4), .AlmostFullThresh(3), .Bypass(1'b1)
    ) u_byp (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (b_flush),
        .valid_i       (b_valid_i),
        .ready_o       (b_ready_o),
        .data_i        (b_data_i),
        .valid_o       (b_valid_o),
        .ready_i       (b_ready_i),
        .data_o        (b_data_o),
        .usage_o       (b_usage_o),
        .almost_full_o (b_almost_full_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic  flush;
        logic  vld;
        logic  rdy;
        byte_t dat;
        logic  e_vld;
        logic  e_rdy;
        byte_t e_dat;
        int    e_use;
        logic  e_af;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        byte_t q[$];
        byte_t cur;
        int    n_in, n_out, cyc, err_dat, err_flag, wraps, rd_m, max_use, guard;

        //           flush vld rdy dat     e_vld e_rdy e_dat  use af
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 8'h00, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, 8'hA1, 1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 8'hA1, 2, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hA4, 1'b1, 1'b1, 8'hA1, 3, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b0, 8'hA1, 4, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1, 8'hA2, 3, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA3, 3, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA4, 2, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hB0, 1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 8'h00, 0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 8'h11, 1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1, 8'h11, 2, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 3, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 8'hC1, 1'b0, 1'b1, 8'h00, 0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'hD1, 1'b1, 1'b1, 8'hC1, 1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hD1, 1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 0, 1'b0};

        rst_i     = 1'b1;
        flush_i   = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        data_i    = '0;
        b_flush   = 1'b0;
        b_valid_i = 1'b0;
        b_ready_i = 1'b0;
        b_data_i  = '0;

        repeat (2) @(negedge clk_i);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);
        chk("rst_usage_o", usage_o, 0);
        chk("rst_almost_full_o", almost_full_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        for (int i = 0; i < NV; i++) begin
            flush_i = vecs[i].flush;
            valid_i = vecs[i].vld;
            ready_i = vecs[i].rdy;
            data_i  = vecs[i].dat;
            @(negedge clk_i);
            chk($sformatf("v%0d_valid_o", i), valid_o, vecs[i].e_vld);
            chk($sformatf("v%0d_ready_o", i), ready_o, vecs[i].e_rdy);
            chk($sformatf("v%0d_usage_o", i), usage_o, vecs[i].e_use);
            chk($sformatf("v%0d_almost_full_o", i), almost_full_o, vecs[i].e_af);
            if (vecs[i].e_vld) begin
                chk($sformatf("v%0d_data_o", i), data_o, vecs[i].e_dat);
            end
            @(posedge clk_i);
            #1;
        end

        // Random traffic against a queue model; pointers start at rd=2 after the table.
        flush_i  = 1'b0;
        n_in     = 0;
        n_out    = 0;
        cyc      = 0;
        err_dat  = 0;
        err_flag = 0;
        wraps    = 0;
        rd_m     = 2;
        max_use  = 0;
        cur      = 8'($urandom);
        while (n_out < 10000 && cyc < 60000) begin
            @(posedge clk_i);
            #1;
            valid_i = (n_in < 10000) && 1'($urandom_range(0, 1));
            ready_i = 1'($urandom_range(0, 1));
            data_i  = cur;
            @(negedge clk_i);
            cyc++;
            if (int'(usage_o) != q.size()) err_flag++;
            if (almost_full_o != (q.size() >= 3)) err_flag++;
            if (valid_o != (q.size() != 0)) err_flag++;
            if (ready_o != (q.size() != 4)) err_flag++;
            if (int'(usage_o) > max_use) max_use = int'(usage_o);
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    err_dat++;
                end else begin
                    if (data_o !== q[0]) err_dat++;
                    void'(q.pop_front());
                end
                n_out++;
                if (rd_m == 3) begin
                    wraps++;
                    rd_m = 0;
                end else begin
                    rd_m++;
                end
            end
            if (valid_i && ready_o) begin
                q.push_back(cur);
                n_in++;
                cur = 8'($urandom);
            end
        end
        chk("rand_words_out", n_out, 10000);
        chk("rand_data_errors", err_dat, 0);
        chk("rand_flag_errors", err_flag, 0);
        chk("rand_max_usage_le_4", max_use <= 4, 1);
        chk("rand_wraps_gt_2000", wraps > 2000, 1);

        // Drain, load two words, then reset mid-stream.
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        guard   = 0;
        while (valid_o && guard < 100) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        chk("drain_in_time", guard < 100, 1);
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hE1;
        @(posedge clk_i);
        #1 data_i = 8'hE2;
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_usage_o", usage_o, 2);
        chk("pre_rst_valid_o", valid_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid_o", valid_o, 0);
        chk("async_rst_usage_o", usage_o, 0);
        chk("async_rst_almost_full_o", almost_full_o, 0);
        chk("async_rst_ready_o", ready_o, 1);
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'hF1;
        @(negedge clk_i);
        chk("post_rst_first_push_ready", ready_o, 1);
        @(posedge clk_i);
        #1 data_i = 8'hF2;
        @(negedge clk_i);
        chk("post_rst_valid_o", valid_o, 1);
        chk("post_rst_data_o", data_o, 8'hF1);
        chk("post_rst_usage_o", usage_o, 1);
        @(posedge clk_i);
        #1 valid_i = 1'b0;

        for (int i = 0; i < 100; i++) begin
            @(posedge clk_i);
            #1;
            b_valid_i = 1'($urandom_range(0, 1));
            b_ready_i = 1'($urandom_range(0, 1));
            b_data_i  = 8'($urandom);
            @(negedge clk_i);
            chk("byp_valid_o", b_valid_o, b_valid_i);
            chk("byp_ready_o", b_ready_o, b_ready_i);
            chk("byp_data_o", b_data_o, b_data_i);
            chk("byp_usage_o", b_usage_o, 0);
            chk("byp_almost_full_o", b_almost_full_o, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
